// File: rtl/z1010_ff_tile.sv
// z1010_ff_tile: serially configured tile of NUM_FF mode-programmable flops.
// Config streams in MSB-first through cfg_din; flops update only while in RUN.
`default_nettype none

module z1010_ff_tile #(
  parameter int NUM_FF = 4,
  parameter int CFG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              cfg_din,
  output logic              cfg_dout,
  output logic              cfg_done,
  output logic              run,
  input  logic [NUM_FF-1:0] d,
  input  logic [NUM_FF-1:0] e,
  input  logic [NUM_FF-1:0] ctl,
  output logic [NUM_FF-1:0] q
);

  localparam int CFG_BITS = NUM_FF * CFG_W;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CFG_BITS-1:0] cfg;
  logic                done_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE, RUN: begin
        // A bit arriving outside LOAD starts a fresh load as bit 0
        if (cfg_en) begin
          state_nxt = LOAD;
          cnt_nxt   = CNT_W'(1);
        end
      end
      LOAD: begin
        if (cfg_en) begin
          if (cnt == CNT_W'(CFG_BITS - 1)) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cfg      <= '0;
      cfg_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cfg_done <= done_nxt;
      if (cfg_en) begin
        cfg <= {cfg[CFG_BITS-2:0], cfg_din};
      end
    end
  end

  assign run      = (state == RUN);
  assign cfg_dout = cfg[CFG_BITS-1];

  generate
    for (genvar i = 0; i < NUM_FF; i++) begin : g_ff
      logic [3:0] mode;
      logic       aclr, aset, use_en, sync_ctl, sync_val, q_r;

      assign mode = cfg[CFG_W*i +: 4];

      always_comb begin
        aclr     = 1'b0;
        aset     = 1'b0;
        use_en   = 1'b0;
        sync_ctl = 1'b0;
        sync_val = 1'b0;
        case (mode)
          4'd1: use_en = 1'b1;
          4'd2: aclr = ~ctl[i];
          4'd3: aset = ~ctl[i];
          4'd4: begin sync_ctl = 1'b1; sync_val = 1'b1; end
          4'd5: sync_ctl = 1'b1;
          4'd6: begin aclr = ~ctl[i]; use_en = 1'b1; end
          4'd7: begin aset = ~ctl[i]; use_en = 1'b1; end
          4'd8: begin sync_ctl = 1'b1; sync_val = 1'b1; use_en = 1'b1; end
          4'd9: begin sync_ctl = 1'b1; use_en = 1'b1; end
          default: ;
        endcase
      end

      // Separate clear/set events so a mode change under a held-low ctl
      // (e.g. mid-load) still re-evaluates the forced value.
      always_ff @(posedge clk or posedge rst or posedge aclr or posedge aset) begin
        if (rst) begin
          q_r <= 1'b0;
        end else if (aclr) begin
          q_r <= 1'b0;
        end else if (aset) begin
          q_r <= 1'b1;
        end else if (state == RUN) begin
          if (sync_ctl && !ctl[i]) begin
            q_r <= sync_val;
          end else if (!use_en || e[i]) begin
            q_r <= d[i];
          end
        end
      end

      assign q[i] = q_r;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_z1010_ff_tile.sv
// tb_z1010_ff_tile: scoreboard bench; stimulus pushes model expectations,
// a monitor pops and compares mid-cycle (async effects) and after each edge.
`default_nettype none

module tb_z1010_ff_tile;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_en = 1'b0;
  logic       cfg_din = 1'b0;
  logic       cfg_dout, cfg_done, run;
  logic [3:0] d = '0, e = '0, ctl = 4'hF, q;

  z1010_ff_tile #(.NUM_FF(4), .CFG_W(4)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_din(cfg_din),
    .cfg_dout(cfg_dout), .cfg_done(cfg_done), .run(run),
    .d(d), .e(e), .ctl(ctl), .q(q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       kind;   // 0 = mid-cycle, 1 = after rising edge
    logic [3:0] q;
    logic       run;
    logic       done;
    logic       dout;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  logic [3:0]  cur_d = '0, cur_e = '0, cur_ctl = 4'hF;

  // Reference model state
  logic [15:0] m_cfg = '0;
  logic [3:0]  m_q = '0;
  int          m_cnt = 0;
  bit          m_load = 0, m_run = 0, m_done = 0;

  function automatic void model_reset();
    m_cfg = '0; m_q = '0; m_cnt = 0; m_load = 0; m_run = 0; m_done = 0;
  endfunction

  function automatic void model_async(input logic [3:0] c);
    for (int i = 0; i < 4; i++) begin
      int md = int'(m_cfg[4*i +: 4]);
      if (!c[i]) begin
        if (md == 2 || md == 6) m_q[i] = 1'b0;
        else if (md == 3 || md == 7) m_q[i] = 1'b1;
      end
    end
  endfunction

  function automatic void model_edge(input logic en, input logic din,
                                     input logic [3:0] dd, input logic [3:0] ee,
                                     input logic [3:0] cc);
    logic [3:0] nq = m_q;
    for (int i = 0; i < 4; i++) begin
      int md = int'(m_cfg[4*i +: 4]);
      bit has_en = (md == 1) || (md >= 6 && md <= 9);
      bit async_m = (md == 2 || md == 3 || md == 6 || md == 7);
      bit sync_m = (md == 4 || md == 5 || md == 8 || md == 9);
      if (async_m && !cc[i])
        nq[i] = (md == 3 || md == 7);
      else if (m_run) begin
        if (sync_m && !cc[i]) nq[i] = (md == 4 || md == 8);
        else if (!has_en || ee[i]) nq[i] = dd[i];
      end
    end
    m_done = 0;
    if (en) begin
      m_cfg = {m_cfg[14:0], din};
      if (!m_load) begin
        m_load = 1; m_run = 0; m_cnt = 1;
      end else begin
        m_cnt++;
      end
      if (m_cnt == 16) begin
        m_load = 0; m_run = 1; m_cnt = 0; m_done = 1;
      end
    end
    m_q = nq;
    model_async(cc);
  endfunction

  function automatic exp_t snap(input logic k);
    exp_t x;
    x.kind = k; x.q = m_q; x.run = m_run; x.done = m_done; x.dout = m_cfg[15];
    return x;
  endfunction

  task automatic step(input logic en, input logic din, input logic r);
    @(negedge clk);
    cfg_en = en; cfg_din = din; d = cur_d; e = cur_e; ctl = cur_ctl; rst = r;
    if (r) model_reset(); else model_async(cur_ctl);
    sb.push_back(snap(1'b0));
    if (!r) model_edge(en, din, cur_d, cur_e, cur_ctl);
    sb.push_back(snap(1'b1));
  endtask

  task automatic load_word(input logic [15:0] w, input int stall_at, input int stall_len);
    for (int b = 15; b >= 0; b--) begin
      if ((15 - b) == stall_at)
        for (int s = 0; s < stall_len; s++) step(1'b0, 1'($urandom), 1'b0);
      step(1'b1, w[b], 1'b0);
    end
  endtask

  task automatic check(input logic k);
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      compared++;
      if (x.kind !== k || q !== x.q || run !== x.run || cfg_done !== x.done ||
          cfg_dout !== x.dout) begin
        mismatched++;
        $display("FAIL %s t=%0t: got q=%h run=%b done=%b dout=%b, want q=%h run=%b done=%b dout=%b",
                 k ? "edge" : "mid", $time, q, run, cfg_done, cfg_dout,
                 x.q, x.run, x.done, x.dout);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk); #2; check(1'b0);
      @(posedge clk); #1; check(1'b1);
    end
  end

  initial begin
    // Reset state, then idle
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // All-dff config, then pass-through
    load_word(16'h0000, 99, 0);
    cur_d = 4'hA;
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // flop0 dffe, flop1 dffes, flop2 dffel, flop3 dffs
    load_word(16'h3971, 99, 0);
    cur_d = 4'h0; cur_e = 4'hF; cur_ctl = 4'hF;
    step(1'b0, 1'b0, 1'b0);
    cur_d = 4'b0001; cur_e = 4'b1110;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    cur_e = 4'hF;
    step(1'b0, 1'b0, 1'b0);
    cur_ctl = 4'b1101;
    step(1'b0, 1'b0, 1'b0);
    cur_ctl = 4'hF; cur_e = 4'hF; cur_d = 4'b0000;
    step(1'b0, 1'b0, 1'b0);
    cur_ctl = 4'b1011; cur_e = 4'b1011; cur_d = 4'hF;
    step(1'b0, 1'b0, 1'b0);
    cur_ctl = 4'hF; cur_e = 4'b1011; cur_d = 4'h0;
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // q=F in RUN, then reset with dffs ctl held low
    cur_d = 4'hF; cur_e = 4'hF; cur_ctl = 4'hF;
    step(1'b0, 1'b0, 1'b0);
    cur_ctl = 4'b0111;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cur_d = 4'($urandom);
      step(1'b0, 1'b0, 1'b0);
    end
    cur_ctl = 4'hF;

    // Stalled load, then reload reading back the previous word
    load_word(16'h1234, 7, 5);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    load_word(16'hFFFF, 99, 0);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Randomized loads and run traffic
    for (int it = 0; it < 60; it++) begin
      cur_ctl = 4'($urandom);
      cur_e = 4'($urandom);
      cur_d = 4'($urandom);
      load_word(16'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 4)));
      for (int k = 0; k < 20; k++) begin
        cur_d = 4'($urandom);
        cur_e = 4'($urandom);
        cur_ctl = 4'($urandom) | 4'($urandom);
        step(1'($urandom_range(0, 15) == 0), 1'($urandom),
             1'($urandom_range(0, 199) == 0));
      end
    end

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    #3;
    if (sb.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/z1010_ff_tile.md
Z1010_FF_TILE -- requirements
Module: z1010_ff_tile

Interface
REQ-001 Parameter NUM_FF, default 4, is the number of configurable flops in the tile (legal 1..16).
REQ-002 Parameter CFG_W, default 4, is the mode-code width per flop (fixed at 4).
REQ-003 clk  input  1  single tile clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cfg_en  input  1  config shift enable; one config bit is accepted per clk while high.
REQ-006 cfg_din  input  1  serial config data in.
REQ-007 cfg_dout  output  1  serial config data out (readback); equals cfg[NUM_FF*4-1].
REQ-008 cfg_done  output  1  one-cycle pulse when the last config bit is accepted.
REQ-009 run  output  1  high while the tile is in RUN.
REQ-010 d  input  NUM_FF  per-flop data.
REQ-011 e  input  NUM_FF  per-flop clock enable, active-high.
REQ-012 ctl  input  NUM_FF  per-flop set/reset control, active-low (sync or async per mode).
REQ-013 q  output  NUM_FF  per-flop registered output.

Function
REQ-014 The config store cfg is NUM_FF*4 bits; flop i mode = cfg[4i+3:4i].
REQ-015 Mode codes: 0 dff, 1 dffe, 2 dffr, 3 dffs, 4 dffh, 5 dffl, 6 dffer, 7 dffes, 8 dffeh, 9 dffel; codes 10-15 behave as dff.
REQ-016 dff: q<=d each edge; dffe: q<=d when e=1, else hold.
REQ-017 dffr/dffs: ctl=0 forces q to 0/1 asynchronously (no clk needed) and holds while low; otherwise q<=d.
REQ-018 dffer/dffes: as dffr/dffs, with clocked load only when e=1.
REQ-019 dffl/dffh: at edge, ctl=0 -> q<=0/1, else q<=d.
REQ-020 dffel/dffeh: at edge, ctl=0 -> q<=0/1 regardless of e; else if e=1 q<=d; else hold (sync control beats enable).
REQ-021 FSM states IDLE, LOAD, RUN; rst -> IDLE.
REQ-022 IDLE: cfg_en=1 -> LOAD, and that cycle's bit is accepted as bit 0.
REQ-023 Each accepted bit: cfg <= {cfg[NUM_FF*4-2:0], cfg_din}; bit counter increments.
REQ-024 LOAD with cfg_en=0: stall, cfg and counter hold; no timeout.
REQ-025 Accepting bit NUM_FF*4-1: cfg_done=1 that cycle's following clock (registered, one cycle), counter -> 0, state -> RUN.
REQ-026 RUN with cfg_en=1: -> LOAD, counter restarts, that bit accepted as bit 0; run drops next cycle.
REQ-027 Clocked q updates (REQ-016..020) occur only in RUN; in IDLE/LOAD q holds.
REQ-028 Async ctl (REQ-017/018) acts in every state using the current cfg mode, including mid-load bit patterns.
REQ-029 cfg_dout readback: after NUM_FF*4 accepted bits the previous cfg contents have appeared on cfg_dout, MSB first.
REQ-030 Async ctl and rst asserted together: rst wins, q=0.

Reset
REQ-031 While rst=1: state IDLE, cfg=0 (all dff), counter=0, q=0, cfg_done=0, run=0, cfg_dout=0.
REQ-032 rst deassertion: first clocked action on the next rising clk; rst mid-LOAD discards partial config.

Verification
REQ-033 NUM_FF=4: shift 16 bits 0x0000 then RUN, d=4'hA -> q=4'hA one clk later; cfg_done pulsed exactly once.
REQ-034 Load flop0=dffe (1): e[0]=0, d[0]=1 for 3 clks -> q[0] holds 0; e[0]=1 -> q[0]=1 next edge.
REQ-035 Load flop1=dffes (7): ctl[1]=0 between edges -> q[1]=1 immediately; ctl[1]=1, e=1, d[1]=0 -> q[1]=0 next edge.
REQ-036 Load flop2=dffel (9): ctl[2]=0, e[2]=0, d=1 -> q[2]=0 at edge; ctl[2]=1, e[2]=0 -> hold.
REQ-037 Load 0x1234, drop cfg_en for 5 clks after 7 bits, finish, then reload 0xFFFF -> cfg_done only after 16th bit; cfg_dout stream = 0x1234 MSB first during reload.
REQ-038 rst pulse mid-RUN with q=4'hF and while ctl low on dffs flop -> q=0, run=0, cfg=0 until next full load.
